// File: rtl/mux_sel_pipe.sv
// mux_sel_pipe: registered N:1 word selector with a valid/ready handshake.
//
// Picks one WIDTH-bit lane out of N packed lanes, indexed either by the external
// binary select (mode=0) or by an internal round-robin scan pointer (mode=1).
// The selected word, its index and an out-of-range flag land in a one-entry
// output register that can be overwritten while it drains, so a beat can move
// every cycle.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        asynchronous reset, active-high
//   in_data    N packed lanes, lane k = in_data[k*WIDTH +: WIDTH]
//   sel        binary lane index (mode=0)
//   mode       0 = direct select, 1 = round-robin scan
//   in_valid   input beat offered
//   in_ready   block can accept a beat this cycle
//   out_data   registered selected word (0 when the index was out of range)
//   out_sel    index that produced out_data
//   out_err    selected index was >= N
//   out_valid  output register holds a beat
//   out_ready  downstream accepts the beat
//
// Build option:
//   MUX_ERR_STICKY_EN  when defined, out_err is sticky until rst: it is set by
//                      any accepted out-of-range beat and survives later beats.

module mux_sel_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N     = 16,
    parameter int unsigned SEL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]   sel,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    output logic               out_err,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [WIDTH-1:0] data_q;
    logic [SEL_W-1:0] sel_q;
    logic             err_q, err_d;
    logic             valid_q;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic [SEL_W-1:0] idx;
    logic             idx_oor;
    logic [WIDTH-1:0] lane_word;
    logic             accept;

    assign idx      = mode ? ptr_q : sel;
    assign idx_oor  = (32'(idx) >= N);
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // An index with no matching lane falls through to zero, which is exactly
    // the out-of-range data value.
    always_comb begin
        lane_word = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (idx == SEL_W'(k)) begin
                lane_word = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // The pointer only lives while scanning; direct mode parks it at lane 0 so
    // a beat accepted on the 0->1 mode edge starts the scan from the bottom.
    always_comb begin
        ptr_d = ptr_q;
        if (!mode) begin
            ptr_d = '0;
        end else if (accept) begin
            ptr_d = (ptr_q == SEL_W'(N - 1)) ? '0 : ptr_q + SEL_W'(1);
        end
    end

    always_comb begin
        err_d = err_q;
        if (accept) begin
`ifdef MUX_ERR_STICKY_EN
            err_d = err_q | idx_oor;
`else
            err_d = idx_oor;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            sel_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            ptr_q <= ptr_d;
            err_q <= err_d;
            if (accept) begin
                data_q  <= lane_word;
                sel_q   <= idx;
                valid_q <= 1'b1;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_data  = data_q;
    assign out_sel   = sel_q;
    assign out_err   = err_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Scoreboard bench for mux_sel_pipe: three instances (N=16, N=5, N=12) share
// one stimulus stream; each has its own reference pointer and expected queue.

module tb_mux_sel_pipe;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  sel;
        logic        err;
    } exp_t;

    localparam int unsigned NumInst = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sel;
    logic        mode;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] base;

    logic [16*16-1:0] din16;
    logic [5*16-1:0]  din5;
    logic [12*16-1:0] din12;

    logic [15:0] od [NumInst];
    logic [3:0]  os [NumInst];
    logic        oe [NumInst];
    logic        ov [NumInst];
    logic        ir [NumInst];

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned pops0 = 0;

    int unsigned inst_n [NumInst] = '{16, 5, 12};
    logic        mv     [NumInst];
    logic [3:0]  mptr   [NumInst];
    logic        msticky[NumInst];
    exp_t        sbq    [NumInst][$];

    always #5 clk = ~clk;

    always_comb begin
        din16 = '0;
        din5  = '0;
        din12 = '0;
        for (int k = 0; k < 16; k++) din16[k*16 +: 16] = base + 16'(k);
        for (int k = 0; k < 5; k++)  din5[k*16 +: 16]  = base + 16'(k);
        for (int k = 0; k < 12; k++) din12[k*16 +: 16] = base + 16'(k);
    end

    mux_sel_pipe #(.WIDTH(16), .N(16), .SEL_W(4)) u_dut16 (
        .clk(clk), .rst(rst), .in_data(din16), .sel(sel), .mode(mode),
        .in_valid(in_valid), .in_ready(ir[0]), .out_data(od[0]), .out_sel(os[0]),
        .out_err(oe[0]), .out_valid(ov[0]), .out_ready(out_ready)
    );

    mux_sel_pipe #(.WIDTH(16), .N(5), .SEL_W(4)) u_dut5 (
        .clk(clk), .rst(rst), .in_data(din5), .sel(sel), .mode(mode),
        .in_valid(in_valid), .in_ready(ir[1]), .out_data(od[1]), .out_sel(os[1]),
        .out_err(oe[1]), .out_valid(ov[1]), .out_ready(out_ready)
    );

    mux_sel_pipe #(.WIDTH(16), .N(12), .SEL_W(4)) u_dut12 (
        .clk(clk), .rst(rst), .in_data(din12), .sel(sel), .mode(mode),
        .in_valid(in_valid), .in_ready(ir[2]), .out_data(od[2]), .out_sel(os[2]),
        .out_err(oe[2]), .out_valid(ov[2]), .out_ready(out_ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model and checker, evaluated half a cycle before each rising edge.
    always @(negedge clk) begin
        for (int i = 0; i < NumInst; i++) begin
            if (rst) begin
                check_eq($sformatf("u%0d.rst_data", i), 32'(od[i]), 32'd0);
                check_eq($sformatf("u%0d.rst_sel", i), 32'(os[i]), 32'd0);
                check_eq($sformatf("u%0d.rst_err", i), 32'(oe[i]), 32'd0);
                check_eq($sformatf("u%0d.rst_valid", i), 32'(ov[i]), 32'd0);
                mv[i]      = 1'b0;
                mptr[i]    = '0;
                msticky[i] = 1'b0;
                sbq[i].delete();
            end else begin
                logic        acc;
                logic        oor;
                logic [3:0]  idx;
                exp_t        e;
                check_eq($sformatf("u%0d.in_ready", i), 32'(ir[i]), 32'(!mv[i] || out_ready));
                check_eq($sformatf("u%0d.out_valid", i), 32'(ov[i]), 32'(mv[i]));
                if (mv[i] && sbq[i].size() > 0) begin
                    e = sbq[i][0];
                    check_eq($sformatf("u%0d.out_data", i), 32'(od[i]), 32'(e.data));
                    check_eq($sformatf("u%0d.out_sel", i), 32'(os[i]), 32'(e.sel));
                    check_eq($sformatf("u%0d.out_err", i), 32'(oe[i]), 32'(e.err));
                end
                acc = in_valid && (!mv[i] || out_ready);
                if (mv[i] && out_ready && sbq[i].size() > 0) begin
                    void'(sbq[i].pop_front());
                    if (i == 0) pops0++;
                end
                if (acc) begin
                    idx = mode ? mptr[i] : sel;
                    oor = (32'(idx) >= inst_n[i]);
                    msticky[i] = msticky[i] | oor;
                    e.data = oor ? 16'h0 : base + 16'(idx);
                    e.sel  = idx;
`ifdef MUX_ERR_STICKY_EN
                    e.err  = msticky[i];
`else
                    e.err  = oor;
`endif
                    sbq[i].push_back(e);
                end
                if (!mode) mptr[i] = '0;
                else if (acc) mptr[i] = (32'(mptr[i]) == inst_n[i] - 1) ? 4'd0 : mptr[i] + 4'd1;
                mv[i] = acc || (mv[i] && !out_ready);
            end
        end
    end

    task automatic step(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; sel = '0; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        base = 16'hA000;
        step(2);
        rst = 1'b0;
        #1 check_eq("idle_in_ready", 32'(ir[0]), 32'd1);
        step(1);

        // Direct select, single beat.
        mode = 1'b0; sel = 4'd5; in_valid = 1'b1; out_ready = 1'b1;
        step(1);
        in_valid = 1'b0;
        check_eq("direct_data", 32'(od[0]), 32'hA005);
        step(2);

        // Back-pressure: first beat held while the second waits, then no bubble.
        out_ready = 1'b0; sel = 4'd3; in_valid = 1'b1;
        step(1);
        sel = 4'd9;
        step(4);
        check_eq("bp_hold_data", 32'(od[0]), 32'hA003);
        out_ready = 1'b1;
        step(1);
        in_valid = 1'b0;
        check_eq("bp_load_data", 32'(od[0]), 32'hA009);
        step(2);

        // Reset while a beat is held.
        out_ready = 1'b0; sel = 4'd7; in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("midrst_data", 32'(od[0]), 32'd0);
        check_eq("midrst_valid", 32'(ov[0]), 32'd0);
        step(1);
        rst = 1'b0;
        #1 check_eq("midrst_in_ready", 32'(ir[0]), 32'd1);
        step(1);

        // Round-robin scan with random sel, then a one-cycle mode drop.
        base = 16'h5000; mode = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            sel = 4'($urandom_range(0, 15));
            step(1);
        end
        mode = 1'b0; in_valid = 1'b0;
        step(1);
        mode = 1'b1; in_valid = 1'b1;
        step(1);
        check_eq("rescan_sel", 32'(os[1]), 32'd0);
        // Stall while scanning: the pointer must move only on accepts.
        out_ready = 1'b0;
        step(3);
        out_ready = 1'b1;
        step(2);
        in_valid = 1'b0;
        step(2);

        // Out-of-range index, then a good one.
        mode = 1'b0; in_valid = 1'b1; sel = 4'd13;
        step(1);
        check_eq("oor_valid", 32'(ov[2]), 32'd1);
        sel = 4'd2;
        step(1);
        in_valid = 1'b0;
        step(2);

        // Full throughput: 32 back-to-back beats.
        base = 16'h3000; pops0 = 0; in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 32; k++) begin
            sel = 4'(k);
            step(1);
        end
        in_valid = 1'b0;
        step(3);
        check_eq("tput_beats", 32'(pops0), 32'd32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
